hazard_ctl: RTL

Pipeline sequencing controller for the CPU datapath. Sits beside the datapath and owns every hazard-unit input: fetch/decode stalls, the upper program-counter select bits, the injected instruction word and the interrupt target address. Arbitrates between decode stall requests, return-address resolution, halt, illegal-opcode traps and external interrupts, and injects a CALL word to enter interrupt handlers.

---
 rtl/hazard_ctl_pkg.sv | 38 +++
 rtl/hazard_ctl_irq_prio_enc.sv | 24 ++
 rtl/hazard_ctl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctl_pkg.sv
// hazard_ctl_pkg
// Shared types and constants for the pipeline hazard controller:
//   state_t     controller FSM states
//   PC_*        encodings driven on hazard_prog_cntr_sel
//   DEF_*       default parameter values (vectors, call word, latencies)
//   vec_addr    interrupt vector computation, wraps modulo 2^14
package hazard_ctl_pkg;

   typedef enum logic [2:0] {
      ST_BOOT     = 3'd0,
      ST_RUN      = 3'd1,
      ST_RET_WAIT = 3'd2,
      ST_INJECT   = 3'd3,
      ST_VECTOR   = 3'd4,
      ST_HALTED   = 3'd5,
      ST_DEAD     = 3'd6
   } state_t;

   localparam logic [2:0] PC_SEQ  = 3'b000;
   localparam logic [2:0] PC_HOLD = 3'b001;
   localparam logic [2:0] PC_INT  = 3'b010;
   localparam logic [2:0] PC_RET  = 3'b011;
   localparam logic [2:0] PC_RST  = 3'b100;

   localparam int          DEF_NUM_IRQ    = 4;
   localparam int          DEF_RET_LAT    = 3;
   localparam logic [13:0] DEF_VEC_BASE   = 14'h0010;
   localparam logic [13:0] DEF_VEC_STRIDE = 14'h0004;
   localparam logic [13:0] DEF_EXC_VEC    = 14'h0008;
   localparam logic [31:0] DEF_CALL_WORD  = 32'h0;

   function automatic logic [13:0] vec_addr(input logic [13:0] base,
                                            input logic [13:0] stride,
                                            input logic [7:0]  idx);
      return base + stride * {6'b0, idx};
   endfunction

endpackage

// File: rtl/hazard_ctl_irq_prio_enc.sv
// irq_prio_enc
// Combinational lowest-index-wins priority encoder.
//   req    in   N      request vector
//   valid  out  1      any request set
//   idx    out  IDX_W  index of lowest set bit (0 when none)
module irq_prio_enc #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   always_comb begin
      valid = |req;
      idx   = '0;
      // Scan downwards so the lowest set index is the last assignment.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/hazard_ctl.sv
// hazard_ctl
// Pipeline sequencing controller: fetch/decode stalls, PC source select,
// CALL-word injection for interrupt entry, return-address sequencing,
// halt and illegal-opcode handling.
//
// Build option: HAZARD_CTL_EXC_TRAP_EN -- when defined, an illegal opcode
// traps through INJECT/VECTOR to EXC_VEC; otherwise the core goes DEAD.
//
// Ports:
//   clock, nreset                      clock, async active-low reset
//   stall_fetch_req, stall_decode_req  decode-stage stall requests
//   halt, illegal_opcode_exception,
//   return_in_pipeline                 decoded events
//   irq_req, irq_en                    level requests and per-line enables
//   stall_fetch, stall_decode          pipeline holds
//   hazard_prog_cntr_sel               PC source (PC_* encodings)
//   inst_word_sel, hazard_inst_word    IF/ID injection
//   prog_cntr_int_addr                 vector for PC_INT
//   irq_ack                            one-hot, one-cycle acknowledge
//   in_isr, halted                     status
//
// state     | meaning
// ----------+-----------------------------------------------------
// BOOT      | one cycle of reset-vector select after reset
// RUN       | normal flow, stall requests pass straight through
// RET_WAIT  | holding PC until return address reaches MEM/WB
// INJECT    | CALL word forced into IF/ID, PC held
// VECTOR    | PC loads vector, irq acknowledged, handler entered
// HALTED    | core halted, pending IRQ wakes it
// DEAD      | fatal stop, only reset leaves
module hazard_ctl
   import hazard_ctl_pkg::*;
#(
   parameter int          NUM_IRQ    = DEF_NUM_IRQ,
   parameter int          RET_LAT    = DEF_RET_LAT,
   parameter logic [13:0] VEC_BASE   = DEF_VEC_BASE,
   parameter logic [13:0] VEC_STRIDE = DEF_VEC_STRIDE,
   parameter logic [13:0] EXC_VEC    = DEF_EXC_VEC,
   parameter logic [31:0] CALL_WORD  = DEF_CALL_WORD
) (
   input  logic               clock,
   input  logic               nreset,
   input  logic               stall_fetch_req,
   input  logic               stall_decode_req,
   input  logic               halt,
   input  logic               illegal_opcode_exception,
   input  logic               return_in_pipeline,
   input  logic [NUM_IRQ-1:0] irq_req,
   input  logic [NUM_IRQ-1:0] irq_en,
   output logic               stall_fetch,
   output logic               stall_decode,
   output logic [2:0]         hazard_prog_cntr_sel,
   output logic               inst_word_sel,
   output logic [31:0]        hazard_inst_word,
   output logic [13:0]        prog_cntr_int_addr,
   output logic [NUM_IRQ-1:0] irq_ack,
   output logic               in_isr,
   output logic               halted
);

   localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
   localparam int CNT_W = (RET_LAT > 1) ? $clog2(RET_LAT) : 1;
   localparam logic [CNT_W-1:0] RET_LOAD = CNT_W'(RET_LAT - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               exc_q, exc_d;

   logic               sf_q, sf_d;
   logic               sd_q, sd_d;
   logic [2:0]         pc_q, pc_d;
   logic               isel_q, isel_d;
   logic [31:0]        word_q, word_d;
   logic [13:0]        addr_q, addr_d;
   logic [NUM_IRQ-1:0] ack_q, ack_d;
   logic               isr_q, isr_d;
   logic               halted_q, halted_d;

   logic               enc_valid;
   logic [IDX_W-1:0]   enc_idx;
   logic               irq_run;

   irq_prio_enc #(
      .N     (NUM_IRQ),
      .IDX_W (IDX_W)
   ) u_prio (
      .req   (irq_req & irq_en),
      .valid (enc_valid),
      .idx   (enc_idx)
   );

   // Handler nesting is blocked in RUN; HALTED wakes on the raw pending set.
   assign irq_run = enc_valid & ~isr_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      exc_d   = exc_q;
      addr_d  = addr_q;
      isr_d   = isr_q;

      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (!stall_decode_req) begin
               if (illegal_opcode_exception) begin
`ifdef HAZARD_CTL_EXC_TRAP_EN
                  state_d = ST_INJECT;
                  exc_d   = 1'b1;
`else
                  state_d = ST_DEAD;
`endif
               end else if (return_in_pipeline) begin
                  state_d = ST_RET_WAIT;
                  cnt_d   = RET_LOAD;
               end else if (irq_run) begin
                  state_d = ST_INJECT;
                  idx_d   = enc_idx;
                  exc_d   = 1'b0;
               end else if (halt) begin
                  state_d = ST_HALTED;
               end
            end
         end
         ST_RET_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RUN;
               isr_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_INJECT: begin
            state_d = ST_VECTOR;
            isr_d   = 1'b1;
            addr_d  = exc_q ? EXC_VEC : vec_addr(VEC_BASE, VEC_STRIDE, 8'(idx_q));
         end
         ST_VECTOR: state_d = ST_RUN;
         ST_HALTED: begin
            if (enc_valid) begin
               state_d = ST_INJECT;
               idx_d   = enc_idx;
               exc_d   = 1'b0;
            end
         end
         ST_DEAD: state_d = ST_DEAD;
         default: state_d = ST_BOOT;
      endcase
   end

   // Outputs are decoded from the next state and registered, so an event
   // sampled at one edge shows its action in the following cycle.
   always_comb begin
      sf_d     = 1'b0;
      sd_d     = 1'b0;
      pc_d     = PC_SEQ;
      isel_d   = 1'b0;
      word_d   = '0;
      ack_d    = '0;
      halted_d = 1'b0;

      case (state_d)
         ST_BOOT: pc_d = PC_RST;
         ST_RET_WAIT: begin
            if (cnt_d == '0) begin
               pc_d = PC_RET;
            end else begin
               pc_d = PC_HOLD;
               sf_d = 1'b1;
            end
         end
         ST_INJECT: begin
            isel_d = 1'b1;
            word_d = CALL_WORD;
            sf_d   = 1'b1;
            pc_d   = PC_HOLD;
         end
         ST_VECTOR: begin
            pc_d  = PC_INT;
            ack_d = exc_q ? '0 : (NUM_IRQ'(1) << idx_q);
         end
         ST_HALTED, ST_DEAD: begin
            sf_d     = 1'b1;
            sd_d     = 1'b1;
            pc_d     = PC_HOLD;
            halted_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state_q  <= ST_BOOT;
         cnt_q    <= '0;
         idx_q    <= '0;
         exc_q    <= 1'b0;
         sf_q     <= 1'b0;
         sd_q     <= 1'b0;
         pc_q     <= PC_RST;
         isel_q   <= 1'b0;
         word_q   <= '0;
         addr_q   <= '0;
         ack_q    <= '0;
         isr_q    <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         exc_q    <= exc_d;
         sf_q     <= sf_d;
         sd_q     <= sd_d;
         pc_q     <= pc_d;
         isel_q   <= isel_d;
         word_q   <= word_d;
         addr_q   <= addr_d;
         ack_q    <= ack_d;
         isr_q    <= isr_d;
         halted_q <= halted_d;
      end
   end

   // RUN passes stall requests through with zero latency.
   assign stall_fetch          = (state_q == ST_RUN) ? (stall_fetch_req | stall_decode_req) : sf_q;
   assign stall_decode         = (state_q == ST_RUN) ? stall_decode_req : sd_q;
   assign hazard_prog_cntr_sel = pc_q;
   assign inst_word_sel        = isel_q;
   assign hazard_inst_word     = word_q;
   assign prog_cntr_int_addr   = addr_q;
   assign irq_ack              = ack_q;
   assign in_isr               = isr_q;
   assign halted               = halted_q;

endmodule
